// File: rtl/dds_wave_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_wave_ctrl
// Brief    : Push-button / auto-sweep sequencer for the dds one-hot wave select.
// Revision : 1.0 - initial release
// ============================================================================
module dds_wave_ctrl #(
  parameter logic [19:0] CNT_MAX   = 20'd999_999,
  parameter logic [25:0] DWELL_MAX = 26'd49_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  input  logic       auto_en,
  output logic [3:0] wave_select,
  output logic       wave_change
);

  localparam logic [19:0] C_CNT_FIRE = CNT_MAX - 20'd1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0000,
    ST_SINE     = 4'b0001,
    ST_SQUARE   = 4'b0010,
    ST_TRIANGLE = 4'b0100,
    ST_SAW      = 4'b1000
  } state_t;

  logic        r_key_meta;
  logic        r_key_s;
  logic [1:0]  r_sync_vld;
  logic        r_key_armed;
  logic [19:0] r_deb_cnt;
  logic        r_key_flag;
  logic [25:0] r_dwell_cnt;
  logic        r_wave_change;
  logic        w_dwell_hit;
  logic        w_advance;
  state_t      r_state;
  state_t      w_state_next;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_key_meta <= 1'b1;
      r_key_s    <= 1'b1;
      r_sync_vld <= 2'b00;
    end else begin
      r_key_meta <= key_in;
      r_key_s    <= r_key_meta;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  // A key held through reset must be seen released before it can fire again;
  // r_sync_vld keeps the reset value of the synchroniser from arming early.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_key_armed <= 1'b0;
    end else if (r_key_s && r_sync_vld[1]) begin
      r_key_armed <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_deb_cnt <= 20'd0;
    end else if (r_key_s) begin
      r_deb_cnt <= 20'd0;
    end else if (r_deb_cnt != CNT_MAX) begin
      r_deb_cnt <= r_deb_cnt + 20'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_key_flag <= 1'b0;
    end else begin
      r_key_flag <= !r_key_s && (r_deb_cnt == C_CNT_FIRE) && r_key_armed;
    end
  end

  assign w_dwell_hit = auto_en && (r_dwell_cnt == DWELL_MAX);
  assign w_advance   = r_key_flag | w_dwell_hit;

  // Any advance restarts the dwell so a manual step still gets a full slot.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dwell_cnt <= 26'd0;
    end else if (!auto_en || w_advance) begin
      r_dwell_cnt <= 26'd0;
    end else begin
      r_dwell_cnt <= r_dwell_cnt + 26'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= ST_IDLE;
      r_wave_change <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_wave_change <= w_advance;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_advance) begin
      case (r_state)
        ST_IDLE:     w_state_next = ST_SINE;
        ST_SINE:     w_state_next = ST_SQUARE;
        ST_SQUARE:   w_state_next = ST_TRIANGLE;
        ST_TRIANGLE: w_state_next = ST_SAW;
        ST_SAW:      w_state_next = ST_IDLE;
        default:     w_state_next = ST_IDLE;
      endcase
    end
  end

  assign wave_select = r_state;
  assign wave_change = r_wave_change;

endmodule
`default_nettype wire
